// File: rtl/codebook_b2_pkg.sv
// -----------------------------------------------------------------------------
// codebook_b2_pkg
// Shared constants and the low-entropy codebook B2 table used by the bit-serial
// B2 decoder. Each table row i describes one codeword:
//   B2_CODE[i]  codeword bits, right-aligned and zero-extended to 12 bits
//   B2_LEN[i]   number of significant bits in B2_CODE[i]
//   B2_CNT[i]   active-prefix count recovered from the codeword
//   B2_DATA[i]  active-prefix data recovered from the codeword
// -----------------------------------------------------------------------------
package codebook_b2_pkg;

   localparam int CODEWORD_LEN_MAX = 12;
   localparam int B2_ENTRIES       = 13;

   typedef logic [3:0]                  len_t;
   typedef logic [CODEWORD_LEN_MAX-1:0] cw_t;

   localparam cw_t B2_CODE [B2_ENTRIES] = '{
      12'b101000,
      12'b111011111,    12'b111100001,
      12'b11111101010,  12'b11111101101,  12'b11111110000,
      12'b11111110110,  12'b11111110011,  12'b11111111001,
      12'b111111111001, 12'b111111111111, 12'b111111110110,
      12'b111111111100
   };

   localparam len_t B2_LEN [B2_ENTRIES] = '{
      4'd6,
      4'd9,  4'd9,
      4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11,
      4'd12, 4'd12, 4'd12, 4'd12
   };

   localparam logic [5:0] B2_CNT [B2_ENTRIES] = '{
      6'd1,
      6'd2, 6'd2,
      6'd2, 6'd2, 6'd3, 6'd3, 6'd3, 6'd3,
      6'd3, 6'd3, 6'd3, 6'd3
   };

   localparam logic [11:0] B2_DATA [B2_ENTRIES] = '{
      12'h00F,
      12'h01F, 12'h02F,
      12'h05F, 12'h06F, 12'h11F, 12'h20F, 12'h12F, 12'h21F,
      12'h14F, 12'h24F, 12'h13F, 12'h23F
   };

endpackage

// File: rtl/codebook_b2_lookup.sv
// -----------------------------------------------------------------------------
// codebook_b2_lookup
// Combinational exact-length match of a candidate bit string against the B2
// table. A candidate only hits a row whose length equals cand_len, so a prefix
// of a longer codeword can never match early.
// Ports:
//   cand_len  in   4       number of significant bits in cand (1..12)
//   cand      in   12      candidate bits, right-aligned, upper bits zero
//   hit       out  1       cand is a B2 codeword of length cand_len
//   ap_cnt    out  6       decoded active-prefix count (0 when no hit)
//   ap_data   out  DATA_W  decoded active-prefix data, zero-extended (0 when no hit)
// -----------------------------------------------------------------------------
module codebook_b2_lookup
   import codebook_b2_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [3:0]                  cand_len,
   input  logic [CODEWORD_LEN_MAX-1:0] cand,
   output logic                        hit,
   output logic [5:0]                  ap_cnt,
   output logic [DATA_W-1:0]           ap_data
);

   always_comb begin
      // NOTE: every output gets a default before the search loop so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      hit     = 1'b0;
      ap_cnt  = '0;
      ap_data = '0;
      // The code is prefix-free, so at most one row can hit.
      for (int i = 0; i < B2_ENTRIES; i++) begin
         if (cand_len == B2_LEN[i] && cand == B2_CODE[i]) begin
            hit     = 1'b1;
            ap_cnt  = B2_CNT[i];
            ap_data = DATA_W'(B2_DATA[i]);
         end
      end
   end

endmodule

// File: rtl/codebook_b2_decoder.sv
// -----------------------------------------------------------------------------
// codebook_b2_decoder
// Bit-serial decoder for low-entropy codebook B2 of the CCSDS-123.0-B-2 hybrid
// entropy coder. Consumes codeword bits MSB-first and emits the recovered
// active-prefix pair through a one-entry output slot. A 12-bit window that
// matches no codeword raises a one-cycle miss pulse and is discarded.
// Ports:
//   clk_i        in   1                    clock, rising edge
//   rst_i        in   1                    asynchronous active-high reset
//   flush_i      in   1                    drop partial codeword, refuse input bit
//   bit_i        in   1                    next codeword bit (MSB first)
//   bit_valid_i  in   1                    bit_i is valid
//   bit_ready_o  out  1                    bit accepted this cycle if valid
//   ap_valid_o   out  1                    output slot holds a decoded pair
//   ap_ready_i   in   1                    downstream takes the pair
//   ap_cnt_o     out  6                    active-prefix count
//   ap_data_o    out  CODEBOOK_LENGTH_MAX  active-prefix data, zero-extended
//   code_len_o   out  6                    length of the decoded codeword
//   miss_o       out  1                    one-cycle pulse on an unmatched window
//   miss_bits_o  out  CODEWORD_LEN_MAX     the unmatched 12 bits
// -----------------------------------------------------------------------------
module codebook_b2_decoder #(
   parameter int CODEBOOK_LENGTH_MAX = 64,
   parameter int CODEWORD_LEN_MAX    = 12
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           bit_i,
   input  logic                           bit_valid_i,
   output logic                           bit_ready_o,
   output logic                           ap_valid_o,
   input  logic                           ap_ready_i,
   output logic [5:0]                     ap_cnt_o,
   output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
   output logic [5:0]                     code_len_o,
   output logic                           miss_o,
   output logic [CODEWORD_LEN_MAX-1:0]    miss_bits_o
);

   import codebook_b2_pkg::*;

   localparam len_t LEN_LAST = len_t'(CODEWORD_LEN_MAX - 1);

   // Only the bits already accepted for the current codeword are kept; the
   // register is cleared at every codeword boundary so the candidate arrives
   // at the lookup right-aligned with zero upper bits.
   logic [CODEWORD_LEN_MAX-2:0]        sr;
   len_t                               len;

   logic                               accept;
   len_t                               cand_len;
   logic [CODEWORD_LEN_MAX-1:0]        cand;
   logic                               hit;
   logic [5:0]                         hit_cnt;
   logic [CODEBOOK_LENGTH_MAX-1:0]     hit_data;

   // A new pair may load whenever the slot is empty or is being drained in
   // the same cycle, so the slot never overflows and never bubbles.
   assign bit_ready_o = !flush_i && (!ap_valid_o || ap_ready_i);
   assign accept      = bit_valid_i && bit_ready_o;
   assign cand_len    = len + len_t'(1);
   assign cand        = {sr, bit_i};

   codebook_b2_lookup #(
      .DATA_W   (CODEBOOK_LENGTH_MAX)
   ) u_lookup (
      .cand_len (cand_len),
      .cand     (cand),
      .hit      (hit),
      .ap_cnt   (hit_cnt),
      .ap_data  (hit_data)
   );

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values; later assignments in the block override
   // earlier ones, which the slot valid logic relies on.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr          <= '0;
         len         <= '0;
         ap_valid_o  <= 1'b0;
         ap_cnt_o    <= '0;
         ap_data_o   <= '0;
         code_len_o  <= '0;
         miss_o      <= 1'b0;
         miss_bits_o <= '0;
      end else begin
         miss_o <= 1'b0;

         if (ap_valid_o && ap_ready_i) begin
            ap_valid_o <= 1'b0;
         end

         if (flush_i) begin
            sr  <= '0;
            len <= '0;
         end else if (accept) begin
            if (hit) begin
               // Overrides the drain above: back-to-back pairs keep valid high.
               ap_valid_o <= 1'b1;
               ap_cnt_o   <= hit_cnt;
               ap_data_o  <= hit_data;
               code_len_o <= 6'(cand_len);
               sr         <= '0;
               len        <= '0;
            end else if (len == LEN_LAST) begin
               miss_o      <= 1'b1;
               miss_bits_o <= cand;
               sr          <= '0;
               len         <= '0;
            end else begin
               sr  <= cand[CODEWORD_LEN_MAX-2:0];
               len <= cand_len;
            end
         end
      end
   end

endmodule
